// File: rtl/scan_frame_rx_pkg.sv
// Shared definitions for the LED-matrix row-scan receiver: default geometry and FSM states.
// Row r of a packed frame occupies bits [r*COLS +: COLS].
package scan_frame_rx_pkg;

    localparam int unsigned ROWS_DEF = 8;
    localparam int unsigned COLS_DEF = 8;

    typedef enum logic {
        HUNT,
        COLLECT
    } scan_state_t;

endpackage

// File: rtl/scan_frame_rx_sync_bus.sv
// W-bit multi-flop synchronizer for a bus asynchronous to clk; async active-low reset to 0.
module sync_bus #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2
)(
    input  logic         clk,
    input  logic         _rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] ff;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/scan_frame_rx.sv
// Rebuilds the 8x8 frame from the scanner's one-hot row strobe and row data,
// publishing only complete in-order frames and flagging protocol violations.
module scan_frame_rx
    import scan_frame_rx_pkg::*;
#(
    parameter int unsigned ROWS        = ROWS_DEF,
    parameter int unsigned COLS        = COLS_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 2
)(
    input  logic                 clk,
    input  logic                 _rst,
    input  logic [ROWS-1:0]      row_in,
    input  logic [COLS-1:0]      data_in,
    output logic [ROWS*COLS-1:0] frame,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 scan_err,
    output logic [15:0]          frames_rx
);

    localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned HW = $clog2(ROWS + 1);
    localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

    logic [ROWS+COLS-1:0] pair_s;
    logic [ROWS+COLS-1:0] pair_q;
    logic [CW-1:0]        cnt;
    logic                 stable;
    logic                 ev_q;
    logic [ROWS-1:0]      ev_row;
    logic [COLS-1:0]      ev_data;

    sync_bus #(
        .W      (ROWS + COLS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        ._rst (_rst),
        .d    ({row_in, data_in}),
        .q    (pair_s)
    );

    assign stable = (pair_s == pair_q);

    // Dwell tracking: the event is registered, so classification acts one cycle after settling.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            pair_q  <= '0;
            cnt     <= '0;
            ev_q    <= 1'b0;
            ev_row  <= '0;
            ev_data <= '0;
        end else begin
            pair_q <= pair_s;
            if (!stable)                cnt <= '0;
            else if (cnt != CW'(SETTLE)) cnt <= cnt + 1'b1;
            ev_q    <= stable && (cnt == CW'(SETTLE - 1));
            ev_row  <= pair_s[ROWS+COLS-1:COLS];
            ev_data <= pair_s[COLS-1:0];
        end
    end

    logic [IW-1:0] k;
    logic [HW-1:0] hits;
    logic          blank;
    logic          multi;

    always_comb begin
        k    = '0;
        hits = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (ev_row[i]) begin
                k    = IW'(i);
                hits = hits + 1'b1;
            end
        end
    end

    assign blank = (hits == '0);
    assign multi = (hits > HW'(1));

    scan_state_t           state;
    logic [IW-1:0]         exp_idx;
    logic [IW-1:0]         prev_idx;
    logic [ROWS*COLS-1:0]  line;
    logic                  pub;

    assign prev_idx = (exp_idx == '0) ? LAST : exp_idx - 1'b1;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state       <= HUNT;
            exp_idx     <= '0;
            line        <= '0;
            pub         <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            scan_err    <= 1'b0;
            frames_rx   <= '0;
        end else begin
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
            pub         <= 1'b0;
            if (pub) begin
                frame       <= line;
                frame_valid <= 1'b1;
                frames_rx   <= frames_rx + 1'b1;
                locked      <= 1'b1;
            end
            if (ev_q && !blank) begin
                if (multi) begin
                    scan_err <= 1'b1;
                    locked   <= 1'b0;
                    state    <= HUNT;
                end else if (state == HUNT) begin
                    if (k == '0) begin
                        line[0 +: COLS] <= ev_data;
                        exp_idx         <= IW'(1);
                        state           <= COLLECT;
                    end
                end else if (k == exp_idx) begin
                    line[k*COLS +: COLS] <= ev_data;
                    if (k == LAST) begin
                        pub     <= 1'b1;
                        exp_idx <= '0;
                    end else begin
                        exp_idx <= exp_idx + 1'b1;
                    end
                end else if (k == prev_idx) begin
                    line[k*COLS +: COLS] <= ev_data;
                end else if (k == '0) begin
                    scan_err        <= 1'b1;
                    locked          <= 1'b0;
                    line[0 +: COLS] <= ev_data;
                    exp_idx         <= IW'(1);
                end else begin
                    scan_err <= 1'b1;
                    locked   <= 1'b0;
                    state    <= HUNT;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_frame_rx.sv
// Directed bench for scan_frame_rx: frame rebuild, hunt, error, glitch and reset scenarios.
module tb_scan_frame_rx;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;

    logic                 clk = 1'b0;
    logic                 _rst;
    logic [ROWS-1:0]      row_in;
    logic [COLS-1:0]      data_in;
    logic [ROWS*COLS-1:0] frame;
    logic                 frame_valid;
    logic                 locked;
    logic                 scan_err;
    logic [15:0]          frames_rx;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int both_cnt = 0;

    scan_frame_rx #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SYNC_STAGES (2),
        .SETTLE      (2)
    ) dut (
        .clk         (clk),
        ._rst        (_rst),
        .row_in      (row_in),
        .data_in     (data_in),
        .frame       (frame),
        .frame_valid (frame_valid),
        .locked      (locked),
        .scan_err    (scan_err),
        .frames_rx   (frames_rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_cnt++;
        if (scan_err) se_cnt++;
        if (frame_valid && scan_err) both_cnt++;
    end

    task automatic dwell(input logic [7:0] r, input logic [7:0] d, input int n);
        row_in  = r;
        data_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        _rst = 1'b0; row_in = '0; data_in = '0;
        repeat (3) @(negedge clk);
        _rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        _rst = 1'b0; row_in = '0; data_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (frame !== 64'h0) begin errors++; $display("FAIL reset.frame got %h want 0", frame); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset.frame_valid got %b want 0", frame_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset.locked got %b want 0", locked); end
        checks++; if (scan_err !== 1'b0) begin errors++; $display("FAIL reset.scan_err got %b want 0", scan_err); end
        checks++; if (frames_rx !== 16'h0) begin errors++; $display("FAIL reset.frames_rx got %0d want 0", frames_rx); end
        _rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int fv0 = fv_cnt;
        int se0 = se_cnt;
        logic [7:0] b;
        for (int r = 0; r < 8; r++) begin
            b = 8'h01 << r;
            dwell(b, b, 20);
        end
        dwell(8'h00, 8'h00, 10);
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL full.frame_valid_count got %0d want 1", fv_cnt - fv0); end
        checks++; if (frame !== 64'h8040201008040201) begin errors++; $display("FAIL full.frame got %h want 8040201008040201", frame); end
        checks++; if (frames_rx !== 16'd1) begin errors++; $display("FAIL full.frames_rx got %0d want 1", frames_rx); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL full.locked got %b want 1", locked); end
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL full.scan_err_count got %0d want 0", se_cnt - se0); end
    endtask

    task automatic test_start_mid();
        int fv0;
        int se0;
        do_reset();
        fv0 = fv_cnt; se0 = se_cnt;
        for (int r = 3; r < 8; r++) dwell(8'h01 << r, 8'hAA, 20);
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL mid.hunt_err_count got %0d want 0", se_cnt - se0); end
        checks++; if (fv_cnt - fv0 != 0) begin errors++; $display("FAIL mid.hunt_valid_count got %0d want 0", fv_cnt - fv0); end
        for (int r = 0; r < 8; r++) dwell(8'h01 << r, 8'hAA, 20);
        dwell(8'h00, 8'h00, 10);
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL mid.frame_valid_count got %0d want 1", fv_cnt - fv0); end
        checks++; if (frame !== {8{8'hAA}}) begin errors++; $display("FAIL mid.frame got %h want all AA", frame); end
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL mid.scan_err_count got %0d want 0", se_cnt - se0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid.locked got %b want 1", locked); end
    endtask

    task automatic test_out_of_order();
        int fv0 = fv_cnt;
        int se0 = se_cnt;
        dwell(8'h01, 8'h55, 20);
        dwell(8'h02, 8'h55, 20);
        dwell(8'h04, 8'h55, 20);
        dwell(8'h20, 8'h55, 20);
        checks++; if (se_cnt - se0 != 1) begin errors++; $display("FAIL ooo.scan_err_count got %0d want 1", se_cnt - se0); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ooo.locked got %b want 0", locked); end
        checks++; if (frame !== {8{8'hAA}}) begin errors++; $display("FAIL ooo.frame got %h want all AA", frame); end
        dwell(8'h40, 8'h55, 20);
        dwell(8'h80, 8'h55, 20);
        dwell(8'h00, 8'h00, 10);
        checks++; if (se_cnt - se0 != 1) begin errors++; $display("FAIL ooo.hunt_err_count got %0d want 1", se_cnt - se0); end
        checks++; if (fv_cnt - fv0 != 0) begin errors++; $display("FAIL ooo.frame_valid_count got %0d want 0", fv_cnt - fv0); end
    endtask

    task automatic test_multi_hot_blank();
        int fv0;
        int se0;
        do_reset();
        fv0 = fv_cnt; se0 = se_cnt;
        for (int r = 0; r < 8; r++) begin
            dwell(8'h01 << r, 8'h10 + 8'(r), 20);
            dwell(8'h00, 8'hFF, 20);
        end
        checks++; if (frame !== 64'h1716151413121110) begin errors++; $display("FAIL blank.frame got %h want 1716151413121110", frame); end
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL blank.frame_valid_count got %0d want 1", fv_cnt - fv0); end
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL blank.scan_err_count got %0d want 0", se_cnt - se0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL blank.locked got %b want 1", locked); end
        dwell(8'b0001_0100, 8'h33, 20);
        dwell(8'h00, 8'h00, 10);
        checks++; if (se_cnt - se0 != 1) begin errors++; $display("FAIL multi.scan_err_count got %0d want 1", se_cnt - se0); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL multi.locked got %b want 0", locked); end
        checks++; if (frame !== 64'h1716151413121110) begin errors++; $display("FAIL multi.frame got %h want 1716151413121110", frame); end
    endtask

    task automatic test_glitch_latency();
        int fv0;
        int se0;
        int lat = -1;
        do_reset();
        fv0 = fv_cnt; se0 = se_cnt;
        for (int r = 0; r < 7; r++) dwell(8'h01 << r, 8'(r), 20);
        dwell(8'h80, 8'hEE, 2);
        dwell(8'h00, 8'h00, 20);
        checks++; if (fv_cnt - fv0 != 0) begin errors++; $display("FAIL glitch.frame_valid_count got %0d want 0", fv_cnt - fv0); end
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL glitch.scan_err_count got %0d want 0", se_cnt - se0); end
        row_in = 8'h80; data_in = 8'h07;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid && lat < 0) lat = i - 1;
            @(negedge clk);
            if (i == 3) begin
                row_in = '0; data_in = '0;
            end
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL latency got %0d want 6", lat); end
        checks++; if (frame !== 64'h0706050403020100) begin errors++; $display("FAIL latency.frame got %h want 0706050403020100", frame); end
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL latency.frame_valid_count got %0d want 1", fv_cnt - fv0); end
    endtask

    task automatic test_reset_midframe();
        int fv0;
        int se0;
        for (int r = 0; r < 4; r++) dwell(8'h01 << r, 8'h99, 20);
        dwell(8'h10, 8'h99, 10);
        #2 _rst = 1'b0;
        #1;
        checks++; if (frame !== 64'h0) begin errors++; $display("FAIL rstmid.frame got %h want 0", frame); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid.locked got %b want 0", locked); end
        checks++; if (frames_rx !== 16'h0) begin errors++; $display("FAIL rstmid.frames_rx got %0d want 0", frames_rx); end
        checks++; if (frame_valid !== 1'b0 || scan_err !== 1'b0) begin errors++; $display("FAIL rstmid.pulses got %b%b want 00", frame_valid, scan_err); end
        row_in = '0; data_in = '0;
        repeat (3) @(negedge clk);
        _rst = 1'b1;
        @(negedge clk);
        fv0 = fv_cnt; se0 = se_cnt;
        for (int r = 0; r < 8; r++) dwell(8'h01 << r, 8'h3C, 20);
        dwell(8'h00, 8'h00, 10);
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL rstmid.frame_valid_count got %0d want 1", fv_cnt - fv0); end
        checks++; if (frames_rx !== 16'd1) begin errors++; $display("FAIL rstmid.frames_rx_after got %0d want 1", frames_rx); end
        checks++; if (frame !== {8{8'h3C}}) begin errors++; $display("FAIL rstmid.frame_after got %h want all 3C", frame); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid.locked_after got %b want 1", locked); end
        checks++; if (se_cnt - se0 != 0) begin errors++; $display("FAIL rstmid.scan_err_count got %0d want 0", se_cnt - se0); end
    endtask

    task automatic test_exclusive_pulses();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive.both_high_cycles got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_start_mid();
        test_out_of_order();
        test_multi_hot_blank();
        test_glitch_latency();
        test_reset_midframe();
        test_exclusive_pulses();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
